// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle for uart_rx_fifo: receiver-side inputs, FWFT output side and status.
// master = the FIFO itself, slave = the surrounding receiver/consumer logic.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BIT_COUNT = 8,
    parameter int unsigned DEPTH          = 16
) ();
    logic                      rx_ready;
    logic [DATA_BIT_COUNT-1:0] rx_data;
    logic                      out_valid;
    logic [DATA_BIT_COUNT-1:0] out_data;
    logic                      out_ack;
    logic [$clog2(DEPTH):0]    count;
    logic                      full;
    logic                      overflow;
    logic                      overflow_clr;

    modport master (
        input  rx_ready,
        input  rx_data,
        input  out_ack,
        input  overflow_clr,
        output out_valid,
        output out_data,
        output count,
        output full,
        output overflow
    );

    modport slave (
        output rx_ready,
        output rx_data,
        output out_ack,
        output overflow_clr,
        input  out_valid,
        input  out_data,
        input  count,
        input  full,
        input  overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Edge-triggered push, first-word-fall-through circular byte FIFO behind the UART receiver.
// Define UART_FIFO_DROP_OLDEST_EN to overwrite the oldest byte on overflow instead of dropping.
module uart_rx_fifo #(
    parameter int unsigned DATA_BIT_COUNT = 8,
    parameter int unsigned DEPTH          = 16
) (
    input logic            clk,
    input logic            rst,
    uart_rx_fifo_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_BIT_COUNT-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             rx_ready_q;

    logic push, pop, is_empty, is_full, wr_en, ovf_evt;

    assign push     = bus.rx_ready & ~rx_ready_q;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign pop      = ~is_empty & bus.out_ack;

    always_comb begin
        wr_en    = 1'b0;
        ovf_evt  = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
            if (!is_full || pop) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                ovf_evt = 1'b1;
`ifdef UART_FIFO_DROP_OLDEST_EN
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
`endif
            end
        end

        if (wr_en && !pop && !ovf_evt) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (bus.overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // Start high so a level already asserted out of reset is not taken as a byte.
            rx_ready_q <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rx_ready_q <= bus.rx_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.out_valid = ~is_empty;
    assign bus.out_data  = mem[rd_ptr_q];
    assign bus.count     = count_q;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_uart_rx_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BIT_COUNT(DW), .DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DATA_BIT_COUNT(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    logic [DW-1:0] mq[$];
    bit            m_prev;
    bit            m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of bytes with the documented push/pop/overflow rules.
    always @(posedge clk) begin
        bit push, pop;
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = 1'b1;
        end else begin
            push   = bus.rx_ready && !m_prev;
            pop    = (mq.size() != 0) && bus.out_ack;
            m_prev = bus.rx_ready;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(bus.rx_data);
                    if (bus.overflow_clr) m_ovf = 1'b0;
                end else begin
                    m_ovf = 1'b1;
`ifdef UART_FIFO_DROP_OLDEST_EN
                    void'(mq.pop_front());
                    mq.push_back(bus.rx_data);
`endif
                end
            end else if (bus.overflow_clr) begin
                m_ovf = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("count", 32'(bus.count), 32'(mq.size()));
            check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (mq.size() != 0) check("out_data", 32'(bus.out_data), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        tick();
    endtask

    task automatic fill(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(DW'(base + DW'(i)));
    endtask

    task automatic drain();
        bus.out_ack = 1'b1;
        repeat (DEPTH + 2) tick();
        bus.out_ack = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_b;
        logic [DW-1:0] last_b;
        rst              = 1'b1;
        bus.rx_ready     = 1'b1;
        bus.rx_data      = '0;
        bus.out_ack      = 1'b0;
        bus.overflow_clr = 1'b0;

        // 1: ready held high through reset must not push
        repeat (3) tick();
        started = 1'b1;
        rst     = 1'b0;
        repeat (3) tick();
        check("t1_count", 32'(bus.count), 0);
        check("t1_valid", 32'(bus.out_valid), 0);
        bus.rx_ready = 1'b0;
        tick();

        // 2: three bytes, then FWFT pops on consecutive cycles
        fill(8'h41, 3);
        check("t2_count", 32'(bus.count), 3);
        check("t2_head", 32'(bus.out_data), 32'h41);
        bus.out_ack = 1'b1;
        tick();
        check("t2_pop1", 32'(bus.out_data), 32'h42);
        tick();
        check("t2_pop2", 32'(bus.out_data), 32'h43);
        tick();
        check("t2_empty", 32'(bus.out_valid), 0);
        bus.out_ack = 1'b0;

        // 3: long ready level stores exactly one byte
        bus.rx_data  = 8'h55;
        bus.rx_ready = 1'b1;
        repeat (40) tick();
        bus.rx_ready = 1'b0;
        tick();
        check("t3_count", 32'(bus.count), 1);
        check("t3_data", 32'(bus.out_data), 32'h55);
        bus.out_ack = 1'b1;
        tick();
        bus.out_ack = 1'b0;

        // 4: overflow while full
        fill(8'h00, 16);
        send_byte(8'hAA);
        check("t4_count", 32'(bus.count), 16);
        check("t4_full", 32'(bus.full), 1);
        check("t4_ovf", 32'(bus.overflow), 1);
`ifdef UART_FIFO_DROP_OLDEST_EN
        check("t4_head", 32'(bus.out_data), 32'h01);
`else
        check("t4_head", 32'(bus.out_data), 32'h00);
`endif
        bus.out_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
`ifdef UART_FIFO_DROP_OLDEST_EN
            exp_b = (i < 15) ? DW'(i + 1) : 8'hAA;
`else
            exp_b = DW'(i);
`endif
            check("t4_drain", 32'(bus.out_data), 32'(exp_b));
            tick();
        end
        bus.out_ack = 1'b0;
        check("t4_empty", 32'(bus.count), 0);

        // 5: push+pop on a full FIFO, then overflow_clr behaviour
        bus.overflow_clr = 1'b1;
        tick();
        bus.overflow_clr = 1'b0;
        check("t5_clr0", 32'(bus.overflow), 0);
        fill(8'h10, 16);
        bus.rx_data  = 8'hBB;
        bus.rx_ready = 1'b1;
        bus.out_ack  = 1'b1;
        tick();
        bus.out_ack  = 1'b0;
        bus.rx_ready = 1'b0;
        tick();
        check("t5_count", 32'(bus.count), 16);
        check("t5_ovf", 32'(bus.overflow), 0);
        check("t5_head", 32'(bus.out_data), 32'h11);
        bus.out_ack = 1'b1;
        last_b = '0;
        for (int i = 0; i < 16; i++) begin
            last_b = bus.out_data;
            tick();
        end
        bus.out_ack = 1'b0;
        check("t5_last", 32'(last_b), 32'hBB);
        fill(8'h20, 16);
        send_byte(8'hCC);
        check("t5_ovf_set", 32'(bus.overflow), 1);
        // clear and a fresh overflow in the same cycle: set wins
        bus.rx_data      = 8'hDD;
        bus.rx_ready     = 1'b1;
        bus.overflow_clr = 1'b1;
        tick();
        bus.rx_ready     = 1'b0;
        bus.overflow_clr = 1'b0;
        tick();
        check("t5_set_wins", 32'(bus.overflow), 1);
        bus.overflow_clr = 1'b1;
        tick();
        bus.overflow_clr = 1'b0;
        check("t5_clr", 32'(bus.overflow), 0);
        drain();
        check("t5_drained", 32'(bus.count), 0);

        // 6: streaming across pointer wrap, then mid-stream reset
        bus.out_ack = 1'b1;
        fill(8'h60, 40);
        tick();
        check("t6_stream_empty", 32'(bus.count), 0);
        bus.out_ack = 1'b0;
        fill(8'hE0, 3);
        check("t6_pre_rst", 32'(bus.count), 3);
        rst = 1'b1;
        tick();
        check("t6_rst_count", 32'(bus.count), 0);
        check("t6_rst_valid", 32'(bus.out_valid), 0);
        rst = 1'b0;
        repeat (2) tick();

        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
